// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for the BCD counter family (up- and down-counters).
//   Provides the digit width, the digit type and a few BCD constants, plus a
//   clamp helper used when loading user-supplied digits.
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_ZERO = 4'd0;
  localparam bcd_t BCD_ONE  = 4'd1;
  localparam bcd_t BCD_NINE = 4'd9;

  // Saturate a digit at an upper limit; the inputs may carry any 4-bit code.
  function automatic bcd_t bcd_clamp(input bcd_t digit, input bcd_t limit);
    return (digit > limit) ? limit : digit;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_down.sv
// ---------------------------------------------------------------------------
// bcd_digit_down
//   One BCD down-counting digit with parallel load.
//   Per rising edge: reset > load > decrement > hold. Decrementing from 0
//   reloads WRAP. The borrow output is combinational so digits can be
//   chained with no added latency: a digit's borrow drives the next digit's
//   enable.
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset (q -> 0)
//   en      decrement enable / borrow-in
//   load    parallel load strobe, dominates en
//   din     value to load (already range-checked by the caller)
//   q       registered digit
//   borrow  en & (q == 0): this digit is about to wrap
// ---------------------------------------------------------------------------
module bcd_digit_down
  import bcd_pkg::*;
#(
  parameter bcd_t WRAP = BCD_NINE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  input  bcd_t din,
  output bcd_t q,
  output logic borrow
);

  // NOTE: reset is tested inside the clocked block, so it is synchronous and
  // only acts on a rising clk edge; it is not in the sensitivity list.
  // NOTE: state registers use non-blocking (<=) assignments so every flop in
  // the design samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= BCD_ZERO;
    end else if (load) begin
      q <= din;
    end else if (en) begin
      q <= (q == BCD_ZERO) ? WRAP : q - BCD_ONE;
    end
  end

  assign borrow = en & (q == BCD_ZERO);

endmodule : bcd_digit_down

// File: rtl/bcd_down_counter.sv
// ---------------------------------------------------------------------------
// bcd_down_counter
//   Two-digit BCD down-counter for countdown timers in the display path.
//   Count-down companion of the mod-60 up-counter; cascades through a
//   combinational borrow in the same way that counter cascades its carry.
//
//   Parameters
//     MAX_TENS      largest tens digit and tens value after a wrap (0..9)
//     MAX_ONES      largest ones digit when tens == MAX_TENS, and ones value
//                   after a wrap (0..9)
//     STOP_AT_ZERO  1: hold at 00 instead of wrapping to MAX_TENS:MAX_ONES
//
//   Ports
//     C_CLK    clock, all state changes on the rising edge
//     RST      synchronous active-low reset, beats LOAD and C_EN
//     C_EN     count enable / borrow-in from the lower stage
//     LOAD     parallel load strobe, beats C_EN
//     LD_DIN1  tens digit to load (clamped to MAX_TENS)
//     LD_DIN0  ones digit to load (clamped to 9, or MAX_ONES at top tens)
//     D_OUT1   tens digit, registered
//     D_OUT0   ones digit, registered
//     B_out    combinational borrow-out to the next-higher stage
//     Z_out    combinational, 1 when the count is 00
//     DONE     registered one-cycle pulse after counting down onto 00
// ---------------------------------------------------------------------------
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int MAX_TENS     = 5,
  parameter int MAX_ONES     = 9,
  parameter bit STOP_AT_ZERO = 1'b0
) (
  input  logic             C_CLK,
  input  logic             RST,
  input  logic             C_EN,
  input  logic             LOAD,
  input  logic [BCD_W-1:0] LD_DIN1,
  input  logic [BCD_W-1:0] LD_DIN0,
  output logic [BCD_W-1:0] D_OUT1,
  output logic [BCD_W-1:0] D_OUT0,
  output logic             B_out,
  output logic             Z_out,
  output logic             DONE
);

  localparam bcd_t MAX_T = bcd_t'(MAX_TENS);
  localparam bcd_t MAX_O = bcd_t'(MAX_ONES);

  // -------------------------------------------------------------------------
  // Load-value clamping
  //   The ones limit is 9 in general; only the top tens value restricts the
  //   ones digit further, so that e.g. MAX 5:9 loads 5:9 but MAX 3:5 turns a
  //   request of 3:A into 3:5 while 2:A still becomes 2:9.
  // -------------------------------------------------------------------------
  bcd_t ld_tens;
  bcd_t ld_ones;
  bcd_t ones_limit;

  // NOTE: every signal driven here gets a value on every path through the
  // block, so no latch is inferred.
  always_comb begin
    ld_tens    = bcd_clamp(LD_DIN1, MAX_T);
    ones_limit = (ld_tens == MAX_T) ? MAX_O : BCD_NINE;
    ld_ones    = bcd_clamp(LD_DIN0, ones_limit);
  end

  // -------------------------------------------------------------------------
  // Digit chain
  //   The ones digit is enabled by C_EN unless a load is pending or we are
  //   parked at 00 in stop mode. Its borrow enables the tens digit, and the
  //   tens borrow therefore fires exactly when the whole counter is at 00
  //   and about to wrap -- which is both B_out and the wrap request.
  //
  //   Wrapping from 00 must land on MAX_TENS:MAX_ONES, but a normal ones
  //   underflow (e.g. 1:0 -> 0:9) must give 9. The digit's own WRAP is used
  //   for the normal case; the 00 wrap is done by loading the maximum, which
  //   takes priority over the decrement inside each digit.
  // -------------------------------------------------------------------------
  logic zero;
  logic stop_hold;
  logic ones_en;
  logic ones_borrow;
  logic tens_borrow;
  logic digit_load;
  bcd_t tens_din;
  bcd_t ones_din;
  bcd_t tens_q;
  bcd_t ones_q;

  assign zero       = (tens_q == BCD_ZERO) && (ones_q == BCD_ZERO);
  assign stop_hold  = zero & STOP_AT_ZERO;
  assign ones_en    = C_EN & ~LOAD & ~stop_hold;

  assign digit_load = LOAD | tens_borrow;
  assign tens_din   = LOAD ? ld_tens : MAX_T;
  assign ones_din   = LOAD ? ld_ones : MAX_O;

  bcd_digit_down #(
    .WRAP (BCD_NINE)
  ) u_ones (
    .clk    (C_CLK),
    .rst_n  (RST),
    .en     (ones_en),
    .load   (digit_load),
    .din    (ones_din),
    .q      (ones_q),
    .borrow (ones_borrow)
  );

  bcd_digit_down #(
    .WRAP (MAX_T)
  ) u_tens (
    .clk    (C_CLK),
    .rst_n  (RST),
    .en     (ones_borrow),
    .load   (digit_load),
    .din    (tens_din),
    .q      (tens_q),
    .borrow (tens_borrow)
  );

  assign D_OUT1 = tens_q;
  assign D_OUT0 = ones_q;
  assign Z_out  = zero;
  assign B_out  = tens_borrow;

  // -------------------------------------------------------------------------
  // DONE: set only by the 01 -> 00 count step. Loads (even of 00), holds,
  // wraps and the stop-mode hold at 00 all clear it, so it is a single pulse.
  // -------------------------------------------------------------------------
  logic at_one;

  assign at_one = (tens_q == BCD_ZERO) && (ones_q == BCD_ONE);

  always_ff @(posedge C_CLK) begin
    if (!RST) begin
      DONE <= 1'b0;
    end else begin
      DONE <= C_EN & ~LOAD & at_one;
    end
  end

endmodule : bcd_down_counter

// File: tb/tb_bcd_down_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_down_counter
//   Directed, table-driven bench for bcd_down_counter. Two instances:
//     u_a : defaults (MAX 5:9, wrapping at 00)
//     u_b : MAX 3:5, STOP_AT_ZERO=1 (exercises the top-tens ones clamp and
//           the hold-at-zero mode)
//   Each vector is driven at the falling edge. B_out is compared just
//   before the next rising edge (it depends on the current state and
//   inputs); digits, DONE and Z_out are compared 1 ns after that edge.
// ---------------------------------------------------------------------------
module tb_bcd_down_counter;

  typedef struct {
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] din1;
    logic [3:0] din0;
    logic       exp_b;     // B_out before the edge
    logic [3:0] exp1;      // D_OUT1 after the edge
    logic [3:0] exp0;      // D_OUT0 after the edge
    logic       exp_done;  // DONE after the edge
    logic       exp_z;     // Z_out after the edge
  } vec_t;

  logic       clk = 1'b0;

  logic       rst_a = 1'b0, en_a = 1'b0, load_a = 1'b0;
  logic [3:0] din1_a = 4'd0, din0_a = 4'd0;
  logic [3:0] q1_a, q0_a;
  logic       b_a, z_a, done_a;

  logic       rst_b = 1'b0, en_b = 1'b0, load_b = 1'b0;
  logic [3:0] din1_b = 4'd0, din0_b = 4'd0;
  logic [3:0] q1_b, q0_b;
  logic       b_b, z_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_down_counter u_a (
    .C_CLK   (clk),
    .RST     (rst_a),
    .C_EN    (en_a),
    .LOAD    (load_a),
    .LD_DIN1 (din1_a),
    .LD_DIN0 (din0_a),
    .D_OUT1  (q1_a),
    .D_OUT0  (q0_a),
    .B_out   (b_a),
    .Z_out   (z_a),
    .DONE    (done_a)
  );

  bcd_down_counter #(
    .MAX_TENS     (3),
    .MAX_ONES     (5),
    .STOP_AT_ZERO (1'b1)
  ) u_b (
    .C_CLK   (clk),
    .RST     (rst_b),
    .C_EN    (en_b),
    .LOAD    (load_b),
    .LD_DIN1 (din1_b),
    .LD_DIN0 (din0_b),
    .D_OUT1  (q1_b),
    .D_OUT0  (q0_b),
    .B_out   (b_b),
    .Z_out   (z_b),
    .DONE    (done_b)
  );

  function automatic vec_t mk(input logic rst, input logic en, input logic load,
                              input logic [3:0] din1, input logic [3:0] din0,
                              input logic exp_b,
                              input logic [3:0] exp1, input logic [3:0] exp0,
                              input logic exp_done, input logic exp_z);
    vec_t v;
    v.rst = rst;   v.en = en;     v.load = load;
    v.din1 = din1; v.din0 = din0; v.exp_b = exp_b;
    v.exp1 = exp1; v.exp0 = exp0; v.exp_done = exp_done; v.exp_z = exp_z;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // sel = 0 drives/checks u_a, sel = 1 drives/checks u_b.
  task automatic run_vec(input bit sel, input vec_t v, input int idx);
    @(negedge clk);
    if (!sel) begin
      rst_a = v.rst; en_a = v.en; load_a = v.load; din1_a = v.din1; din0_a = v.din0;
    end else begin
      rst_b = v.rst; en_b = v.en; load_b = v.load; din1_b = v.din1; din0_b = v.din0;
    end
    #1;
    check(sel ? "b_borrow" : "a_borrow", idx, {7'd0, sel ? b_b : b_a}, {7'd0, v.exp_b});
    @(posedge clk);
    #1;
    check(sel ? "b_count" : "a_count", idx,
          sel ? {q1_b, q0_b} : {q1_a, q0_a}, {v.exp1, v.exp0});
    check(sel ? "b_done" : "a_done", idx,
          {7'd0, sel ? done_b : done_a}, {7'd0, v.exp_done});
    check(sel ? "b_zero" : "a_zero", idx,
          {7'd0, sel ? z_b : z_a}, {7'd0, v.exp_z});
  endtask

  vec_t tab_a[$];
  vec_t tab_b[$];

  initial begin
    //                rst en ld d1  d0    b   q1 q0 dn z
    // Reset (overrides load and enable), then load 0:3 and count down.
    tab_a.push_back(mk(0, 1, 1, 7,  7,    0,  0, 0, 0, 1));
    tab_a.push_back(mk(1, 0, 1, 0,  3,    0,  0, 3, 0, 0));
    tab_a.push_back(mk(1, 1, 0, 0,  0,    0,  0, 2, 0, 0));
    tab_a.push_back(mk(1, 1, 0, 0,  0,    0,  0, 1, 0, 0));
    tab_a.push_back(mk(1, 1, 0, 0,  0,    0,  0, 0, 1, 1));
    // At 00 with enable: borrow out now, wrap to 5:9, DONE drops.
    tab_a.push_back(mk(1, 1, 0, 0,  0,    1,  5, 9, 0, 0));
    tab_a.push_back(mk(1, 0, 0, 0,  0,    0,  5, 9, 0, 0));
    // Tens borrow: 1:0 -> 0:9.
    tab_a.push_back(mk(1, 0, 1, 1,  0,    0,  1, 0, 0, 0));
    tab_a.push_back(mk(1, 1, 0, 0,  0,    0,  0, 9, 0, 0));
    // Load beats enable, with clamping; no decrement on the load edge.
    tab_a.push_back(mk(1, 1, 1, 7, 12,    0,  5, 9, 0, 0));
    tab_a.push_back(mk(1, 1, 1, 3, 10,    0,  3, 9, 0, 0));
    tab_a.push_back(mk(1, 0, 1, 6,  3,    0,  5, 3, 0, 0));
    // Reset mid-count together with load.
    tab_a.push_back(mk(1, 0, 1, 4,  7,    0,  4, 7, 0, 0));
    tab_a.push_back(mk(1, 1, 0, 0,  0,    0,  4, 6, 0, 0));
    tab_a.push_back(mk(0, 1, 1, 2,  2,    0,  0, 0, 0, 1));
    // Load while at 00 with enable: no borrow; loading 00 clears DONE.
    tab_a.push_back(mk(1, 1, 1, 0,  1,    0,  0, 1, 0, 0));
    tab_a.push_back(mk(1, 1, 0, 0,  0,    0,  0, 0, 1, 1));
    tab_a.push_back(mk(1, 1, 1, 0,  0,    0,  0, 0, 0, 1));
    tab_a.push_back(mk(1, 0, 0, 0,  0,    0,  0, 0, 0, 1));
    tab_a.push_back(mk(1, 1, 0, 0,  0,    1,  5, 9, 0, 0));
    tab_a.push_back(mk(1, 1, 0, 0,  0,    0,  5, 8, 0, 0));
    tab_a.push_back(mk(1, 0, 1, 2,  5,    0,  2, 5, 0, 0));

    // Stop-at-zero instance, MAX 3:5.
    tab_b.push_back(mk(0, 0, 0, 0,  0,    0,  0, 0, 0, 1));
    tab_b.push_back(mk(1, 1, 0, 0,  0,    0,  0, 0, 0, 1));
    tab_b.push_back(mk(1, 0, 1, 0,  2,    0,  0, 2, 0, 0));
    tab_b.push_back(mk(1, 1, 0, 0,  0,    0,  0, 1, 0, 0));
    tab_b.push_back(mk(1, 1, 0, 0,  0,    0,  0, 0, 1, 1));
    tab_b.push_back(mk(1, 1, 0, 0,  0,    0,  0, 0, 0, 1));
    tab_b.push_back(mk(1, 1, 0, 0,  0,    0,  0, 0, 0, 1));
    tab_b.push_back(mk(1, 1, 0, 0,  0,    0,  0, 0, 0, 1));
    // Ones clamp is MAX_ONES only at the top tens value.
    tab_b.push_back(mk(1, 1, 1, 7, 12,    0,  3, 5, 0, 0));
    tab_b.push_back(mk(1, 0, 1, 3, 10,    0,  3, 5, 0, 0));
    tab_b.push_back(mk(1, 0, 1, 3,  4,    0,  3, 4, 0, 0));
    tab_b.push_back(mk(1, 0, 1, 2, 10,    0,  2, 9, 0, 0));
    tab_b.push_back(mk(1, 1, 0, 0,  0,    0,  2, 8, 0, 0));
    // Ones underflow reloads 9, not MAX_ONES.
    tab_b.push_back(mk(1, 0, 1, 1,  0,    0,  1, 0, 0, 0));
    tab_b.push_back(mk(1, 1, 0, 0,  0,    0,  0, 9, 0, 0));
    tab_b.push_back(mk(1, 1, 1, 3,  0,    0,  3, 0, 0, 0));
    tab_b.push_back(mk(1, 1, 0, 0,  0,    0,  2, 9, 0, 0));

    for (int i = 0; i < tab_a.size(); i++) run_vec(1'b0, tab_a[i], i);

    // Hold at 2:5 for ten edges with C_EN=0.
    for (int i = 0; i < 10; i++)
      run_vec(1'b0, mk(1, 0, 0, 0, 0, 0, 2, 5, 0, 0), 100 + i);

    for (int i = 0; i < tab_b.size(); i++) run_vec(1'b1, tab_b[i], i);

    // Multi-cycle stop-mode run: five enabled edges from 0:2 give one DONE
    // pulse and never a borrow.
    begin
      int done_cnt;
      done_cnt = 0;
      run_vec(1'b1, mk(1, 0, 1, 0, 2, 0, 0, 2, 0, 0), 200);
      @(negedge clk);
      load_b = 1'b0;
      en_b   = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("b_stop_borrow", 300 + i, {7'd0, b_b}, 8'd0);
        if (done_b) done_cnt++;
      end
      check("b_stop_value", 300, {q1_b, q0_b}, 8'h00);
      check("b_done_pulses", 300, 8'(done_cnt), 8'd1);
      en_b = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_bcd_down_counter
